// File: rtl/de0_lt24_sopc_cpu_mul_seq.sv
// Sequential 32x32 multiplier built on a shared, pipelined 16x16 unsigned cell.
// Four partial products are issued, accumulated as they return, then sign-corrected.
module de0_lt24_sopc_cpu_mul_seq #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] mc_a,
  output logic [15:0] mc_b,
  input  logic [31:0] mc_p
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCorr, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        tag_v_q [MUL_LATENCY];
  logic        tag_v_d [MUL_LATENCY];
  logic [1:0]  tag_i_q [MUL_LATENCY];
  logic [1:0]  tag_i_d [MUL_LATENCY];

  logic        accept;
  logic        issue;
  logic        ret_v;
  logic [1:0]  ret_i;
  logic [63:0] pp;
  logic [31:0] hi;
  logic [31:0] corr;

  assign accept = start && (state_q == StIdle || state_q == StDone);
  assign issue  = (state_q == StIssue);
  assign ret_v  = tag_v_q[MUL_LATENCY-1];
  assign ret_i  = tag_i_q[MUL_LATENCY-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (cnt_q == 2'd3) state_d = StDrain;
      StDrain: if (ret_v && ret_i == 2'd3) state_d = StCorr;
      StCorr:  state_d = StDone;
      StDone:  state_d = start ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (accept) begin
      a_d   = src1;
      b_d   = src2;
      op_d  = op;
      cnt_d = 2'd0;
    end else if (issue) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Each issue is tagged so a returning product knows its weight.
  always_comb begin
    tag_v_d[0] = issue;
    tag_i_d[0] = cnt_q;
    for (int i = 1; i < int'(MUL_LATENCY); i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_i_d[i] = tag_i_q[i-1];
    end
  end

  always_comb begin
    pp = {32'd0, mc_p};
    unique case (ret_i)
      2'd0:    pp = {32'd0, mc_p};
      2'd3:    pp = {mc_p, 32'd0};
      default: pp = {16'd0, mc_p, 16'd0};
    endcase
    acc_d = acc_q;
    if (accept) acc_d = 64'd0;
    else if (ret_v) acc_d = acc_q + pp;
  end

  // The unsigned high word is fixed up for signed operands.
  always_comb begin
    hi   = acc_q[63:32];
    corr = hi;
    unique case (op_q)
      2'b10:   corr = hi - (a_q[31] ? b_q : 32'd0) - (b_q[31] ? a_q : 32'd0);
      2'b11:   corr = hi - (a_q[31] ? b_q : 32'd0);
      default: corr = hi;
    endcase
    result_d = result_q;
    if (state_q == StCorr) result_d = (op_q == 2'b00) ? acc_q[31:0] : corr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 2'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        tag_v_q[i] <= 1'b0;
        tag_i_q[i] <= 2'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      for (int i = 0; i < int'(MUL_LATENCY); i++) begin
        tag_v_q[i] <= tag_v_d[i];
        tag_i_q[i] <= tag_i_d[i];
      end
    end
  end

  always_comb begin
    busy   = !reset && (state_q == StIssue || state_q == StDrain || state_q == StCorr);
    done   = !reset && (state_q == StDone);
    result = reset ? 32'd0 : result_q;
    mc_a   = 16'd0;
    mc_b   = 16'd0;
    if (!reset && issue) begin
      mc_a = cnt_q[0] ? a_q[31:16] : a_q[15:0];
      mc_b = cnt_q[1] ? b_q[31:16] : b_q[15:0];
    end
  end

endmodule

// File: tb/tb_de0_lt24_sopc_cpu_mul_seq.sv
// Bench for the sequential multiplier: two instances (latency 1 and 3), each with
// its own pipelined 16x16 cell model, checked against 64-bit reference arithmetic.
module tb_de0_lt24_sopc_cpu_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, sel;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        busy1, done1, busy3, done3;
  logic [31:0] res1, res3, mcp1, mcp3;
  logic [15:0] mca1, mcb1, mca3, mcb3;
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  de0_lt24_sopc_cpu_mul_seq #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start & ~sel), .op(op), .src1(src1), .src2(src2),
    .busy(busy1), .done(done1), .result(res1), .mc_a(mca1), .mc_b(mcb1), .mc_p(mcp1)
  );

  de0_lt24_sopc_cpu_mul_seq #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start & sel), .op(op), .src1(src1), .src2(src2),
    .busy(busy3), .done(done3), .result(res3), .mc_a(mca3), .mc_b(mcb3), .mc_p(mcp3)
  );

  always @(posedge clk) begin
    pipe1    <= {16'd0, mca1} * {16'd0, mcb1};
    pipe3[0] <= {16'd0, mca3} * {16'd0, mcb3};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mcp1 = pipe1;
  assign mcp3 = pipe3[2];

  logic        busy_s, done_s;
  logic [31:0] res_s;
  logic [15:0] mca_s, mcb_s;
  assign busy_s = sel ? busy3 : busy1;
  assign done_s = sel ? done3 : done1;
  assign res_s  = sel ? res3 : res1;
  assign mca_s  = sel ? mca3 : mca1;
  assign mcb_s  = sel ? mcb3 : mcb1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (lat %0d): got %0h expected %0h", name, sel ? 3 : 1, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (o == 2'b10 || o == 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (o == 2'b10) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle N, then check every cycle through N+7+lat.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    logic [1:0] idx;
    logic [15:0] ea, eb;
    lat = sel ? 3 : 1;
    op = o; src1 = a; src2 = b; start = 1'b1;
    for (int c = 1; c <= 7 + lat; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0; src1 = $urandom; src2 = $urandom; op = 2'($urandom);
      end
      ea = 16'd0; eb = 16'd0;
      if (c <= 4) begin
        idx = 2'(c - 1);
        ea = idx[0] ? a[31:16] : a[15:0];
        eb = idx[1] ? b[31:16] : b[15:0];
      end
      chk({name, " busy"}, 64'(busy_s), 64'(c <= 5 + lat));
      chk({name, " done"}, 64'(done_s), 64'(c == 6 + lat));
      chk({name, " mc_a"}, 64'(mca_s), 64'(ea));
      chk({name, " mc_b"}, 64'(mcb_s), 64'(eb));
      if (c >= 6 + lat) chk({name, " result"}, 64'(res_s), 64'(exp));
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];
  int   done_at [$];
  logic [31:0] ra, rb;
  logic [1:0]  ro;

  initial begin
    vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};

    sel = 1'b0; reset = 1'b1; start = 1'b1; op = 2'b00; src1 = 32'd3; src2 = 32'd5;
    tick();
    tick();
    chk("reset busy", 64'(busy1 | busy3), 64'd0);
    chk("reset done", 64'(done1 | done3), 64'd0);
    chk("reset result", 64'(res1 | res3), 64'd0);
    chk("reset mc", 64'({mca1, mcb1, mca3, mcb3}), 64'd0);
    start = 1'b0; reset = 1'b0;
    tick();
    chk("idle busy", 64'(busy1 | busy3), 64'd0);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 4; i++) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, "vec");
    end

    // Start pulse while busy is ignored.
    sel = 1'b0; done_at.delete();
    op = 2'b00; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c == 3);
      if (done1) done_at.push_back(c);
    end
    chk("ignored start done count", 64'(done_at.size()), 64'd1);
    if (done_at.size() > 0) chk("ignored start done cycle", 64'(done_at[0]), 64'd7);
    chk("ignored start result", 64'(res1), 64'd63);

    // Start held through DONE gives back-to-back operations.
    done_at.delete();
    op = 2'b00; src1 = 32'd11; src2 = 32'd13; start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 7) begin
        op = 2'b10; src1 = 32'hFFFF_FFFE; src2 = 32'h8000_0000;
      end
      if (c >= 8) start = 1'b0;
      if (done1) begin
        done_at.push_back(c);
        if (c == 7) chk("b2b first result", 64'(res1), 64'd143);
        if (c == 14) chk("b2b second result", 64'(res1),
                         64'(ref_mul(2'b10, 32'hFFFF_FFFE, 32'h8000_0000)));
      end
    end
    chk("b2b done count", 64'(done_at.size()), 64'd2);
    if (done_at.size() == 2) begin
      chk("b2b first done", 64'(done_at[0]), 64'd7);
      chk("b2b second done", 64'(done_at[1]), 64'd14);
    end

    // Reset mid-operation aborts cleanly.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      op = 2'b01; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick();
        start = 1'b0;
        reset = (c == 3);
      end
      chk("abort busy", 64'(busy_s), 64'd0);
      chk("abort done", 64'(done_s), 64'd0);
      chk("abort result", 64'(res_s), 64'd0);
      done_at.delete();
      for (int c = 1; c <= 15; c++) begin
        tick();
        if (done_s) done_at.push_back(c);
      end
      chk("abort no done", 64'(done_at.size()), 64'd0);
      run_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, "post-reset");
    end

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 25; i++) begin
        ra = $urandom; rb = $urandom; ro = 2'($urandom);
        if (i % 5 == 0) ra[31] = 1'b1;
        if (i % 7 == 0) rb[31] = 1'b1;
        run_op(ro, ra, rb, ref_mul(ro, ra, rb), "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de0_lt24_sopc_cpu_mul_seq.md
DE0_LT24_SOPC_CPU_MUL_SEQ -- requirements
Module: de0_lt24_sopc_cpu_mul_seq

Interface
REQ-001 The block SHALL have parameter MUL_LATENCY, default 1, giving the cycles from mc_a/mc_b driven to the product on mc_p; legal range 1..3.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request pulse; sampled only when the block is able to accept.
REQ-005 op  in  2  operation: 00 MUL (low 32 bits), 01 MULXUU, 10 MULXSS, 11 MULXSU (a signed, b unsigned); the three MULX ops return the high 32 bits.
REQ-006 src1, src2  in  32  operands a and b.
REQ-007 busy  out  1  high while an operation is in flight.
REQ-008 done  out  1  one-cycle pulse; result is valid in that cycle.
REQ-009 result  out  32  last completed result; held until the next done.
REQ-010 mc_a, mc_b  out  16  operand halves driven to the shared unsigned 16x16 multiplier cell.
REQ-011 mc_p  in  32  unsigned product returned by the cell MUL_LATENCY cycles after issue.

Function
REQ-012 The block SHALL use states IDLE, ISSUE, DRAIN, CORR and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch src1, src2 and op and go to ISSUE; start SHALL be ignored in every other state.
REQ-014 ISSUE SHALL last exactly 4 cycles, issuing one partial product per cycle, index 0..3:
  - 0 = (a[15:0], b[15:0])
  - 1 = (a[31:16], b[15:0])
  - 2 = (a[15:0], b[31:16])
  - 3 = (a[31:16], b[31:16])
REQ-015 mc_a and mc_b SHALL be 0 in every cycle with no issue.
REQ-016 A MUL_LATENCY-deep valid/index shift register SHALL tag each issue; mc_p SHALL be accumulated only in a cycle whose tag is valid.
REQ-017 Accumulation SHALL be a 64-bit unsigned sum mod 2^64: P += mc_p << (0, 16, 16, 32) for index (0, 1, 2, 3).
REQ-018 DRAIN SHALL follow ISSUE and exit to CORR after the cycle in which the index-3 product is accumulated.
REQ-019 CORR (one cycle) SHALL compute H = P[63:32] mod 2^32 as follows:
  - MULXSS: H minus (a[31] ? b : 0) minus (b[31] ? a : 0).
  - MULXSU: H minus (a[31] ? b : 0).
  - MULXUU: H unchanged.
REQ-020 CORR SHALL register result = P[31:0] for MUL and the corrected H otherwise.
REQ-021 Timing for start sampled in cycle N:
  - busy = 1 in cycles N+1 .. N+5+MUL_LATENCY.
  - done = 1 only in cycle N+6+MUL_LATENCY, with busy = 0.
  - The state SHALL then return to IDLE unless a new start is accepted in that DONE cycle.
REQ-022 The latency in REQ-021 SHALL be identical for all op values.
REQ-023 Back-to-back throughput SHALL be one operation per 6+MUL_LATENCY cycles when start is asserted in each DONE cycle.
REQ-024 Operand or op changes on the inputs after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-025 While reset=1, the block SHALL force:
  - state IDLE;
  - busy, done, result, mc_a and mc_b to 0;
  - accumulator and valid/index shift register cleared.
REQ-026 Reset SHALL take priority over start in the same cycle.
REQ-027 On reset mid-operation, products still arriving on mc_p SHALL be discarded and no done SHALL be produced for the aborted operation.
REQ-028 After reset deasserts, the next accepted operation SHALL complete with the correct result.

Verification
REQ-029 MUL_LATENCY=1, op=MUL, src1=0x0001_0003, src2=0x0002_0005, start at cycle N -> busy in N+1..N+6, done at N+7, result=0x000B_000F.
REQ-030 op=MULXUU, src1=src2=0xFFFF_FFFF -> result=0xFFFF_FFFE; mc_a/mc_b sequence FFFF/FFFF four times, then 0.
REQ-031 op=MULXSS, src1=src2=0xFFFF_FFFF -> result=0x0000_0000; op=MULXSU, src1=0xFFFF_FFFF, src2=0x0000_0002 -> result=0xFFFF_FFFF.
REQ-032 start pulsed at N+3 while busy -> ignored, exactly one done; start held high through the DONE cycle -> second operation accepted, its done 7 cycles after the first done.
REQ-033 reset asserted one cycle at N+3 of a MULXUU -> next cycle busy=0, done=0, result=0, no done follows; a fresh MUL 3*5 then returns 0x0000_000F.
REQ-034 Repeat REQ-029..REQ-031 with MUL_LATENCY=3 -> same results, done at N+9; random signed/unsigned operands checked against a 64-bit reference model.
